uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame, legal 5..16.
REQ-002 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1 or 2.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = LSB sent first, 0 = MSB sent first.
REQ-004 SHALL have port CLK, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port TICK, input, 1: bit-period strobe; each asserted cycle ends one bit period.
REQ-007 SHALL have port P_DATA, input, DATA_WIDTH: parallel payload.
REQ-008 SHALL have port Data_Valid, input, 1: P_DATA valid this cycle.
REQ-009 SHALL have port PAR_EN, input, 1: parity bit enable, sampled with P_DATA.
REQ-010 SHALL have port PAR_TYP, input, 1: 0 = even, 1 = odd, sampled with P_DATA.
REQ-011 SHALL have port Ready, output, 1: holding buffer empty, word acceptable.
REQ-012 SHALL have port Busy, output, 1: frame on line.
REQ-013 SHALL have port TX_OUT, output, 1: serial line, idle high.
REQ-014 SHALL have port Frame_Done, output, 1: single-cycle end-of-frame pulse.

Function
REQ-015 SHALL accept a word when Data_Valid && Ready at a rising edge: P_DATA, PAR_EN and PAR_TYP go to a one-entry holding buffer, and Ready drops the next cycle.
REQ-016 SHALL ignore Data_Valid while Ready is low; held contents stay unchanged and no error is flagged.
REQ-017 SHALL use an FSM with states IDLE, START, DATA, PARITY, STOP; all state advances occur only on cycles with TICK=1.
REQ-018 IDLE: TX_OUT=1, Busy=0; on TICK with buffer full, move buffer to shift register, go to START, and set Ready=1 the next cycle.
REQ-019 START: TX_OUT=0 for one bit period, then go to DATA.
REQ-020 DATA: send DATA_WIDTH bits in order set by LSB_FIRST; a bit counter of width $clog2(DATA_WIDTH+1) ends the state at count DATA_WIDTH-1 on TICK.
REQ-021 After DATA: go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
REQ-022 PARITY: TX_OUT = XOR of latched payload for even; inverted XOR for odd.
REQ-023 STOP: TX_OUT=1 for STOP_BITS bit periods.
REQ-024 On the TICK ending the last stop bit, Frame_Done SHALL pulse 1 for one cycle; if the buffer is full, go directly to START with no idle bit, otherwise go to IDLE.
REQ-025 Busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-026 TX_OUT SHALL be registered with no glitches; each bit changes one cycle after the TICK edge.
REQ-027 A new word may be accepted during any frame state; the buffer refills independently of the shift register.
REQ-028 Buffer-to-shift transfer and new accept SHALL NOT occur in the same cycle, because Ready is low while full.
REQ-029 PAR_EN and PAR_TYP changes mid-frame SHALL NOT affect the current frame.

Reset
REQ-030 RST=1 at a rising edge SHALL force IDLE, TX_OUT=1, Busy=0, Ready=1 and Frame_Done=0, and clear the buffer, shift register and counters.
REQ-031 Reset mid-frame SHALL abort the frame without emitting Frame_Done; the line is high from the next cycle.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the PAR_EVEN/PAR_ODD constants and the legal parameter ranges.
REQ-033 Parity generation SHALL be a sub-module uart_parity_calc (DATA_WIDTH payload, PAR_TYP → parity bit).
REQ-034 RTL SHALL be 120-400 lines including the sub-module.

Verification
REQ-035 TICK=1 constantly, accept 0xA5 with PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; Frame_Done pulses on cycle 11.
REQ-036 0xA5 with PAR_TYP=1, then 0x00 with PAR_EN=0 queued mid-frame -> parity bit 1; second frame 0,00000000,1 starts immediately with no idle bit; two Frame_Done pulses.
REQ-037 TICK every 16 cycles, STOP_BITS=2 -> each bit held 16 cycles; stop high for 32 cycles; Busy high for 192 cycles (PAR_EN=1).
REQ-038 Data_Valid held high for 3 words while Ready is low -> only words accepted at Ready=1 are sent; none are duplicated or dropped.
REQ-039 RST pulsed during DATA bit 4 -> TX_OUT=1, Busy=0, Ready=1 the next cycle; no Frame_Done.
REQ-040 LSB_FIRST=0, DATA_WIDTH=5, 0x13 -> data bits 1,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 16;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for one payload word; odd parity inverts the XOR reduction.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-word holding buffer feeding a TICK-paced
// start/data/parity/stop serializer with a registered line output.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  TX_OUT,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_param
    $error("uart_tx_framer: illegal DATA_WIDTH or STOP_BITS");
  end

  tx_state_e             state;
  logic [DATA_WIDTH-1:0] buf_data, shreg, shreg_nxt;
  logic                  buf_par_en, buf_par_typ, buf_par_bit;
  logic                  ready_q, par_en_q, par_bit_q;
  logic [CW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic                  tx_q, busy_q, done_q;
  logic                  accept, load, last_stop, next_bit;

  assign Ready      = ready_q;
  assign Busy       = busy_q;
  assign TX_OUT     = tx_q;
  assign Frame_Done = done_q;

  // Ready is low exactly while the buffer is full, so accept and load are exclusive.
  assign accept    = Data_Valid & ready_q;
  assign last_stop = (int'(stop_cnt) == STOP_BITS - 1);
  assign load      = TICK & ~ready_q &
                     ((state == ST_IDLE) | ((state == ST_STOP) & last_stop));

  assign next_bit  = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_WIDTH-1];
  assign shreg_nxt = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (buf_data),
    .par_typ (buf_par_typ),
    .par_bit (buf_par_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_q     <= 1'b1;
      buf_data    <= '0;
      buf_par_en  <= 1'b0;
      buf_par_typ <= PAR_EVEN;
    end else if (accept) begin
      ready_q     <= 1'b0;
      buf_data    <= P_DATA;
      buf_par_en  <= PAR_EN;
      buf_par_typ <= PAR_TYP;
    end else if (load) begin
      ready_q     <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        // Parity and enable are frozen with the payload for the whole frame.
        state     <= ST_START;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        shreg     <= buf_data;
        par_en_q  <= buf_par_en;
        par_bit_q <= buf_par_bit;
        stop_cnt  <= 1'b0;
        if (state == ST_STOP) done_q <= 1'b1;
      end else if (TICK) begin
        case (state)
          ST_IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          ST_START: begin
            state   <= ST_DATA;
            tx_q    <= next_bit;
            shreg   <= shreg_nxt;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
              if (par_en_q) begin
                state <= ST_PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              tx_q    <= next_bit;
              shreg   <= shreg_nxt;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            state    <= ST_STOP;
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
          end
          ST_STOP: begin
            if (last_stop) begin
              state  <= ST_IDLE;
              tx_q   <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              stop_cnt <= ~stop_cnt;
            end
          end
          default: begin
            state  <= ST_IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations checked against a
// frame-level bit-list model of the serial line.
module tb_uart_tx_framer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TICK = 1'b1;
  logic [15:0] p_data = '0;
  logic        dv = 1'b0, par_en = 1'b0, par_typ = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  rdy_v, busy_v, tx_v, fd_v;
  logic        cur_rdy, cur_busy, cur_tx, cur_fd;

  int passed = 0;
  int total  = 0;

  int cfg_w   [3] = '{8, 8, 5};
  int cfg_st  [3] = '{1, 2, 1};
  int cfg_lsb [3] = '{1, 1, 0};

  logic [15:0] words [4];
  bit          pes   [4];
  bit          pts   [4];
  bit          exp_tx[$];
  bit          exp_fd[$];

  always #5 CLK = ~CLK;

  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1), .LSB_FIRST(1)) dut_a (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(p_data[7:0]),
    .Data_Valid(dv && sel == 2'd0), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .Ready(rdy_v[0]), .Busy(busy_v[0]), .TX_OUT(tx_v[0]), .Frame_Done(fd_v[0]));

  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(2), .LSB_FIRST(1)) dut_b (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(p_data[7:0]),
    .Data_Valid(dv && sel == 2'd1), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .Ready(rdy_v[1]), .Busy(busy_v[1]), .TX_OUT(tx_v[1]), .Frame_Done(fd_v[1]));

  uart_tx_framer #(.DATA_WIDTH(5), .STOP_BITS(1), .LSB_FIRST(0)) dut_c (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(p_data[4:0]),
    .Data_Valid(dv && sel == 2'd2), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .Ready(rdy_v[2]), .Busy(busy_v[2]), .TX_OUT(tx_v[2]), .Frame_Done(fd_v[2]));

  assign cur_rdy  = rdy_v[sel];
  assign cur_busy = busy_v[sel];
  assign cur_tx   = tx_v[sel];
  assign cur_fd   = fd_v[sel];

  // Model: a frame is start(0), payload in configured order, optional parity, stop 1s.
  // Frame_Done is seen on the cycle right after a frame's last stop bit.
  task automatic add_frame(input logic [15:0] w, input bit e, input bit t);
    int dw;
    bit p, b;
    dw = cfg_w[sel];
    p  = t;
    exp_fd.push_back(exp_tx.size() > 0);
    exp_tx.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      b = (cfg_lsb[sel] != 0) ? w[i] : w[dw-1-i];
      p = p ^ w[i];
      exp_tx.push_back(b);
      exp_fd.push_back(1'b0);
    end
    if (e) begin
      exp_tx.push_back(p);
      exp_fd.push_back(1'b0);
    end
    for (int i = 0; i < cfg_st[sel]; i++) begin
      exp_tx.push_back(1'b1);
      exp_fd.push_back(1'b0);
    end
  endtask

  // Keeps Data_Valid high until all n words are taken; while Ready is low the
  // bus carries junk that must be ignored. TICK is held high, one bit per cycle.
  task automatic run_stream(input string name, input int n);
    bit got_tx[$];
    bit got_fd[$];
    int idx;
    bit started, acc, r;
    idx = 0;
    started = 0;
    exp_tx.delete();
    exp_fd.delete();
    for (int i = 0; i < n; i++) add_frame(words[i], pes[i], pts[i]);
    exp_tx.push_back(1'b1); exp_fd.push_back(1'b1);
    exp_tx.push_back(1'b1); exp_fd.push_back(1'b0);
    for (int cyc = 0; cyc < 400 && got_tx.size() < exp_tx.size(); cyc++) begin
      @(negedge CLK);
      r = cur_rdy;
      if (idx < n && r) begin
        dv = 1'b1; p_data = words[idx]; par_en = pes[idx]; par_typ = pts[idx];
      end else begin
        dv = (idx < n); p_data = 16'($urandom);
        par_en = 1'($urandom); par_typ = 1'($urandom);
      end
      @(posedge CLK);
      acc = dv && r;
      #1;
      if (started) begin
        got_tx.push_back(cur_tx);
        got_fd.push_back(cur_fd);
      end
      if (acc) begin
        idx++;
        started = 1;
        total++;
        if (cur_rdy !== 1'b0) $display("FAIL %s ready_drop: got %b want 0", name, cur_rdy);
        else passed++;
      end
    end
    dv = 1'b0;
    total++;
    if (got_tx.size() != exp_tx.size())
      $display("FAIL %s length: got %0d want %0d", name, got_tx.size(), exp_tx.size());
    else passed++;
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i] || got_fd[i] !== exp_fd[i])
        $display("FAIL %s bit%0d: got tx=%b fd=%b want tx=%b fd=%b",
                 name, i, got_tx[i], got_fd[i], exp_tx[i], exp_fd[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (tx_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || rdy_v[s] !== 1'b1 || fd_v[s] !== 1'b0)
        $display("FAIL reset_state dut%0d: got tx=%b busy=%b rdy=%b fd=%b want 1 0 1 0",
                 s, tx_v[s], busy_v[s], rdy_v[s], fd_v[s]);
      else passed++;
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_basic();
    sel = 2'd0;
    words[0] = 16'h00A5; pes[0] = 1; pts[0] = 0;
    run_stream("basic_a5_even", 1);
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    words[0] = 16'h00A5; pes[0] = 1; pts[0] = 1;
    words[1] = 16'h0000; pes[1] = 0; pts[1] = 0;
    run_stream("back_to_back", 2);
  endtask

  task automatic test_held_valid();
    sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      words[i] = 16'($urandom); pes[i] = 1'($urandom); pts[i] = 1'($urandom);
    end
    run_stream("held_valid", 3);
  endtask

  task automatic test_msb_first();
    sel = 2'd2;
    words[0] = 16'h0013; pes[0] = 0; pts[0] = 0;
    run_stream("msb_first_13", 1);
  endtask

  task automatic test_random();
    int n;
    for (int round = 0; round < 6; round++) begin
      sel = 2'(round % 3);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        words[i] = 16'($urandom); pes[i] = 1'($urandom); pts[i] = 1'($urandom);
      end
      run_stream($sformatf("random%0d", round), n);
    end
  endtask

  task automatic test_slow_tick();
    bit got[$];
    int nfd, bad;
    logic [15:0] w;
    sel = 2'd1;
    w = 16'($urandom);
    nfd = 0;
    bad = 0;
    exp_tx.delete();
    exp_fd.delete();
    @(negedge CLK);
    par_en = 1'b1;
    par_typ = 1'($urandom);
    add_frame(w, 1'b1, par_typ);
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge CLK);
      TICK = (cyc % 16 == 3);
      dv = (cyc == 1);
      p_data = w;
      @(posedge CLK);
      #1;
      if (cur_busy) got.push_back(cur_tx);
      if (cur_fd) nfd++;
    end
    @(negedge CLK);
    TICK = 1'b1;
    dv = 1'b0;
    total++;
    if (got.size() != 192) $display("FAIL slow_busy_len: got %0d want 192", got.size());
    else passed++;
    total++;
    if (got.size() != 16 * exp_tx.size())
      $display("FAIL slow_model_len: got %0d want %0d", got.size(), 16 * exp_tx.size());
    else passed++;
    for (int j = 0; j < got.size() && j / 16 < exp_tx.size(); j++)
      if (got[j] !== exp_tx[j/16]) bad++;
    total++;
    if (bad != 0) $display("FAIL slow_bits: got %0d wrong cycles want 0", bad);
    else passed++;
    total++;
    if (nfd != 1) $display("FAIL slow_frame_done: got %0d pulses want 1", nfd);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w1;
    bit bad;
    sel = 2'd0;
    w1 = 16'($urandom);
    bad = 0;
    @(negedge CLK);
    dv = 1'b1; p_data = w1; par_en = 1'b1; par_typ = 1'b0;
    @(posedge CLK);
    // Queue a second word so the reset must also empty the buffer.
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      dv = (k <= 3); p_data = 16'($urandom);
      @(posedge CLK);
    end
    #1;
    total++;
    if (cur_tx !== w1[4]) $display("FAIL rst_pre_bit4: got %b want %b", cur_tx, w1[4]);
    else passed++;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_rdy !== 1'b1 || cur_fd !== 1'b0)
      $display("FAIL rst_mid: got tx=%b busy=%b rdy=%b fd=%b want 1 0 1 0",
               cur_tx, cur_busy, cur_rdy, cur_fd);
    else passed++;
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_fd !== 1'b0) bad = 1;
    end
    total++;
    if (bad) $display("FAIL rst_quiet: got line activity after reset want idle");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_held_valid();
    test_msb_first();
    test_slow_tick();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
